av_io_responder: RTL and testbench

Generic responder for one device slot on the I/O bridge's master port. It accepts classic cyc/stb/we/sel cycles qualified by the bridge's per-device chip select and provides a byte-writable register bank with a read-only ID word. Acknowledge latency is programmable. The acknowledge is held until strobe negates, which is what the bridge's wait-for-ack / wait-for-nack sequencing expects. Write pulses and the register contents go to the device core.

---
 rtl/av_io_responder.sv | 156 +++++++++++++++
 tb/tb_av_io_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/av_io_responder.sv
// rtl/av_io_responder.sv - chip-selected cyc/stb responder with byte-writable register bank
module av_io_responder #(
    parameter int          NREGS    = 16,
    parameter int          LAT      = 2,
    parameter logic [31:0] ID_VALUE = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cs_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [3:0]            sel_i,
    input  logic [31:0]           adr_i,
    input  logic [31:0]           dat_i,
    output logic                  ack_o,
    output logic                  stall_o,
    output logic [31:0]           dat_o,
    output logic [32*NREGS-1:0]   regs_o,
    output logic                  wr_o,
    output logic [3:0]            wr_idx_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]  state_q;
    logic [2:0]  cnt_q;
    logic        we_q;
    logic        swap_q;
    logic [3:0]  sel_q;
    logic [3:0]  idx_q;
    logic [31:0] dat_q;

    // Register 0 is the constant ID word, so only 1..NREGS-1 need storage.
    logic [31:0] regs_q [1:NREGS-1];

    logic        req;
    logic        commit;
    logic        idx_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_sel;
    logic [31:0] rd_word;
    logic [31:0] rd_data;

    logic        unused_adr;
    assign unused_adr = ^{adr_i[31:8], adr_i[6], adr_i[1:0]};

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    assign req       = cs_i && cyc_i && stb_i;
    assign commit    = (state_q == ST_WAIT) && cyc_i && cs_i && (cnt_q == 3'd0);
    assign idx_valid = int'(idx_q) < NREGS;
    assign wr_data   = swap_q ? bswap(dat_q) : dat_q;
    assign wr_sel    = swap_q ? {sel_q[0], sel_q[1], sel_q[2], sel_q[3]} : sel_q;
    assign rd_data   = swap_q ? bswap(rd_word) : rd_word;
    assign stall_o   = (state_q != ST_IDLE);

    always_comb begin
        rd_word = 32'd0;
        if (idx_q == 4'd0) begin
            rd_word = ID_VALUE;
        end
        for (int k = 1; k < NREGS; k++) begin
            if (idx_q == 4'(k)) begin
                rd_word = regs_q[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            we_q     <= 1'b0;
            swap_q   <= 1'b0;
            sel_q    <= 4'd0;
            idx_q    <= 4'd0;
            dat_q    <= 32'd0;
            ack_o    <= 1'b0;
            dat_o    <= 32'd0;
            wr_o     <= 1'b0;
            wr_idx_o <= 4'd0;
        end else begin
            wr_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we_i;
                        swap_q  <= adr_i[7];
                        sel_q   <= sel_i;
                        idx_q   <= adr_i[5:2];
                        dat_q   <= dat_i;
                        cnt_q   <= 3'(LAT - 1);
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Losing cyc or the chip select abandons the access silently.
                    if (!cyc_i || !cs_i) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 3'd0) begin
                        state_q <= ST_ACK;
                        ack_o   <= 1'b1;
                        if (we_q) begin
                            dat_o <= 32'd0;
                            if (idx_valid) begin
                                wr_o     <= 1'b1;
                                wr_idx_o <= idx_q;
                            end
                        end else begin
                            dat_o <= rd_data;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_ACK: begin
                    if (!stb_i) begin
                        ack_o   <= 1'b0;
                        dat_o   <= 32'd0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 1; k < NREGS; k++) begin
                regs_q[k] <= 32'd0;
            end
        end else if (commit && we_q) begin
            for (int k = 1; k < NREGS; k++) begin
                if (idx_q == 4'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_sel[b]) begin
                            regs_q[k][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    assign regs_o[31:0] = ID_VALUE;
    for (genvar g = 1; g < NREGS; g++) begin : g_regs_out
        assign regs_o[32*g +: 32] = regs_q[g];
    end

endmodule

// File: tb/tb_av_io_responder.sv
// tb/tb_av_io_responder.sv - randomized model-checked bench for av_io_responder
module tb_av_io_responder;

    localparam int          NREGS = 8;
    localparam int          LAT   = 2;
    localparam logic [31:0] ID    = 32'hA5C3_0001;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 cs_i, cyc_i, stb_i, we_i;
    logic [3:0]           sel_i;
    logic [31:0]          adr_i, dat_i;
    logic                 ack_o, stall_o, wr_o;
    logic [31:0]          dat_o;
    logic [32*NREGS-1:0]  regs_o;
    logic [3:0]           wr_idx_o;

    av_io_responder #(.NREGS(NREGS), .LAT(LAT), .ID_VALUE(ID)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cs_i(cs_i), .cyc_i(cyc_i), .stb_i(stb_i),
        .we_i(we_i), .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i), .ack_o(ack_o),
        .stall_o(stall_o), .dat_o(dat_o), .regs_o(regs_o), .wr_o(wr_o), .wr_idx_o(wr_idx_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [16];
    logic        exp_ack, exp_stall, exp_wr;
    logic [31:0] exp_dat;
    logic [3:0]  exp_wr_idx;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [32*NREGS-1:0] model_vec();
        logic [32*NREGS-1:0] v;
        for (int k = 0; k < NREGS; k++) v[32*k +: 32] = (k == 0) ? ID : mregs[k];
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] adr);
        int idx;
        logic [31:0] v;
        idx = int'(adr[5:2]);
        if (idx == 0) v = ID;
        else if (idx < NREGS) v = mregs[idx];
        else v = 32'd0;
        return adr[7] ? bswap(v) : v;
    endfunction

    task automatic model_write(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] sel);
        int idx;
        logic [31:0] d;
        logic [3:0] s;
        idx = int'(adr[5:2]);
        d = adr[7] ? bswap(data) : data;
        s = adr[7] ? {sel[0], sel[1], sel[2], sel[3]} : sel;
        if (idx >= 1 && idx < NREGS) begin
            for (int b = 0; b < 4; b++) if (s[b]) mregs[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) mregs[k] = 32'd0;
        exp_ack = 0; exp_stall = 0; exp_wr = 0; exp_dat = 0; exp_wr_idx = 0;
    endtask

    always @(negedge clk_i) begin
        chk("ack", 256'(ack_o), 256'(exp_ack));
        chk("stall", 256'(stall_o), 256'(exp_stall));
        chk("dat", 256'(dat_o), 256'(exp_dat));
        chk("wr", 256'(wr_o), 256'(exp_wr));
        if (exp_wr) chk("wr_idx", 256'(wr_idx_o), 256'(exp_wr_idx));
        chk("regs", 256'(regs_o), 256'(model_vec()));
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic access(input bit we, input logic [31:0] adr, input logic [31:0] data,
                          input logic [3:0] sel, input int hold, input int abort_at,
                          input bit keep_cyc, output logic [31:0] rdat);
        bit aborted;
        aborted = 0;
        rdat = 32'd0;
        cs_i = 1; cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; dat_i = data; sel_i = sel;
        tick();
        exp_stall = 1;
        // Request fields must be latched at the sample edge, so scramble them afterwards.
        we_i = 1'($urandom); adr_i = $urandom; dat_i = $urandom; sel_i = 4'($urandom);
        for (int k = 1; k <= LAT && !aborted; k++) begin
            if (abort_at == k) begin
                if ($urandom_range(0, 1) == 1) cs_i = 0;
                else begin cyc_i = 0; stb_i = 0; end
            end
            tick();
            if (abort_at == k) begin
                aborted = 1;
                exp_stall = 0;
                cs_i = 0; cyc_i = 0; stb_i = 0;
            end
        end
        if (!aborted) begin
            exp_ack = 1;
            if (we) begin
                model_write(adr, data, sel);
                exp_dat = 0;
                exp_wr = (int'(adr[5:2]) < NREGS);
                exp_wr_idx = adr[5:2];
            end else begin
                exp_dat = model_read(adr);
            end
            rdat = dat_o;
            for (int h = 0; h < hold; h++) begin
                tick();
                exp_wr = 0;
            end
            stb_i = 0;
            if (!keep_cyc) begin cyc_i = 0; cs_i = 0; end
            tick();
            exp_wr = 0; exp_ack = 0; exp_dat = 0; exp_stall = 0;
        end
    endtask

    initial begin
        logic [31:0] r, adr, data;
        rst_ni = 0; cs_i = 0; cyc_i = 0; stb_i = 0; we_i = 0; sel_i = 0; adr_i = 0; dat_i = 0;
        model_reset();
        repeat (3) tick();
        chk("lit_reset_id", 256'(regs_o[31:0]), 256'(32'hA5C3_0001));
        chk("lit_reset_ack", 256'(ack_o), 256'(1'b0));
        rst_ni = 1;
        tick();

        access(0, 32'h00, 0, 4'h0, 0, 0, 0, r);
        chk("lit_read_id", 256'(r), 256'(32'hA5C3_0001));

        access(1, 32'h04, 32'h1122_3344, 4'b0101, 0, 0, 0, r);
        chk("lit_reg1_bytes", 256'(regs_o[63:32]), 256'(32'h0022_0044));
        access(0, 32'h04, 0, 4'h0, 0, 0, 0, r);
        chk("lit_read_reg1", 256'(r), 256'(32'h0022_0044));

        access(1, 32'h88, 32'h1122_3344, 4'hF, 0, 0, 0, r);
        chk("lit_reg2_swap", 256'(regs_o[95:64]), 256'(32'h4433_2211));
        access(0, 32'h88, 0, 4'h0, 0, 0, 0, r);
        chk("lit_read_swap", 256'(r), 256'(32'h1122_3344));
        access(0, 32'h08, 0, 4'h0, 0, 0, 0, r);
        chk("lit_read_plain", 256'(r), 256'(32'h4433_2211));

        access(1, 32'h0C, 32'hDEAD_BEEF, 4'hF, 0, LAT, 0, r);
        chk("lit_abort_reg3", 256'(regs_o[127:96]), 256'(32'h0));
        tick();

        access(0, 32'h04, 0, 4'h0, 5, 0, 1, r);
        access(1, 32'h04, 32'hA0B0_C0D0, 4'hF, 0, 0, 0, r);
        chk("lit_rmw_reg1", 256'(regs_o[63:32]), 256'(32'hA0B0_C0D0));

        cs_i = 0; cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 32'h04; dat_i = 32'h5555_5555; sel_i = 4'hF;
        repeat (4) tick();
        cyc_i = 0; stb_i = 0;
        chk("lit_nocs_reg1", 256'(regs_o[63:32]), 256'(32'hA0B0_C0D0));

        access(1, 32'h3C, 32'h1234_5678, 4'hF, 0, 0, 0, r);
        access(0, 32'h3C, 0, 4'h0, 0, 0, 0, r);
        chk("lit_read_oob", 256'(r), 256'(32'h0));
        access(1, 32'h00, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, r);
        chk("lit_id_kept", 256'(regs_o[31:0]), 256'(32'hA5C3_0001));

        // Reset arriving between edges during WAIT must discard the pending write.
        cs_i = 1; cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 32'h14; dat_i = 32'hFFFF_FFFF; sel_i = 4'hF;
        tick();
        exp_stall = 1;
        tick();
        #2 rst_ni = 0;
        model_reset();
        #1;
        chk("lit_async_stall", 256'(stall_o), 256'(1'b0));
        chk("lit_async_reg1", 256'(regs_o[63:32]), 256'(32'h0));
        cs_i = 0; cyc_i = 0; stb_i = 0;
        tick();
        rst_ni = 1;
        tick();
        chk("lit_async_reg5", 256'(regs_o[191:160]), 256'(32'h0));

        for (int n = 0; n < 300; n++) begin
            bit we, keep;
            int hold, ab, gap;
            we = 1'($urandom_range(0, 1));
            adr = $urandom;
            adr[5:2] = 4'($urandom_range(0, 15));
            data = $urandom;
            hold = $urandom_range(0, 3);
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, LAT)) : 0;
            keep = 1'($urandom_range(0, 1));
            access(we, adr, data, 4'($urandom_range(0, 15)), hold, ab, keep, r);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cs_i = 0; cyc_i = 1'($urandom); stb_i = 1'($urandom); we_i = 1'($urandom);
                tick();
            end
        end
        cs_i = 0; cyc_i = 0; stb_i = 0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
